// File: rtl/bsg_fifo_credit_sender.sv
// bsg_fifo_credit_sender: credit-gated sender for a remote FIFO, with write-pointer mirror and drain FSM
// Ports:
//   clk_i, reset_i    clock, asynchronous active-high reset
//   v_i               client has an element to send
//   ready_o, send_o   send permitted / send launched this cycle (v_i & ready_o)
//   wptr_r_o          remote slot address used by the current send
//   credit_return_i   credits handed back by the remote side this cycle
//   credits_r_o       free remote slots currently known
//   drain_i           level request to stop sending and wait for all credits
//   drained_o         high while fully drained
//   overflow_o        sticky: more credits came back than were ever sent
module bsg_fifo_credit_sender #(
  parameter int els_p = 1024,
  parameter int max_return_p = 4,
  localparam int ptr_width_lp = $clog2(els_p),
  localparam int cnt_width_lp = $clog2(els_p+1),
  localparam int ret_width_lp = $clog2(max_return_p+1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic                    send_o,
  output logic [ptr_width_lp-1:0] wptr_r_o,
  input  logic [ret_width_lp-1:0] credit_return_i,
  output logic [cnt_width_lp-1:0] credits_r_o,
  input  logic                    drain_i,
  output logic                    drained_o,
  output logic                    overflow_o
);
  // wide enough that even an illegal, all-ones return on a full count cannot wrap
  localparam int sum_width_lp = (cnt_width_lp > ret_width_lp ? cnt_width_lp : ret_width_lp) + 1;
  localparam logic [cnt_width_lp-1:0] full_lp = cnt_width_lp'(els_p);
  localparam logic [sum_width_lp-1:0] full_sum_lp = sum_width_lp'(els_p);
  localparam logic [ptr_width_lp-1:0] last_lp = ptr_width_lp'(els_p-1);
  typedef enum logic [1:0] {eRun, eDrain, eDone} state_e;
  state_e state_r, state_n;
  logic [sum_width_lp-1:0] credits_n;
  logic over;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state_r <= eRun;
    else state_r <= state_n;
  // dropping drain_i always wins, so an abort is honoured even on the cycle credits become full
  always_comb
    state_n = (state_r == eRun)   ? (drain_i ? eDrain : eRun)
            : (state_r == eDrain) ? (!drain_i ? eRun : (credits_r_o == full_lp ? eDone : eDrain))
            : (drain_i ? eDone : eRun);
  always_comb begin
    ready_o = (state_r == eRun) & ~drain_i & (credits_r_o != '0);
    send_o = v_i & ready_o;
    drained_o = (state_r == eDone);
  end
  assign credits_n = sum_width_lp'(credits_r_o) - sum_width_lp'(send_o) + sum_width_lp'(credit_return_i);
  assign over = credits_n > full_sum_lp;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      credits_r_o <= full_lp;
      wptr_r_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      credits_r_o <= over ? full_lp : credits_n[cnt_width_lp-1:0];
      overflow_o <= overflow_o | over;
      if (send_o) wptr_r_o <= (wptr_r_o == last_lp) ? '0 : wptr_r_o + 1'b1;
    end
endmodule

// File: tb/tb_bsg_fifo_credit_sender.sv
// tb_bsg_fifo_credit_sender: scoreboard bench for the credit sender (small and default depths)
module tb_bsg_fifo_credit_sender;
  logic clk = 0, rst = 1;
  logic v_i = 0, drain_i = 0;
  logic [1:0] ret_i = 0;
  logic ready_o, send_o, drained_o, overflow_o;
  logic [1:0] wptr_o;
  logic [2:0] credits_o;
  logic v1 = 0;
  logic ready1, send1, drained1, ov1;
  logic [9:0] wptr1;
  logic [10:0] cred1;
  always #5 clk = ~clk;
  bsg_fifo_credit_sender #(.els_p(4), .max_return_p(2)) dut (
    .clk_i(clk), .reset_i(rst), .v_i(v_i), .ready_o(ready_o), .send_o(send_o),
    .wptr_r_o(wptr_o), .credit_return_i(ret_i), .credits_r_o(credits_o),
    .drain_i(drain_i), .drained_o(drained_o), .overflow_o(overflow_o));
  bsg_fifo_credit_sender u1 (
    .clk_i(clk), .reset_i(rst), .v_i(v1), .ready_o(ready1), .send_o(send1),
    .wptr_r_o(wptr1), .credit_return_i(3'd0), .credits_r_o(cred1),
    .drain_i(1'b0), .drained_o(drained1), .overflow_o(ov1));
  typedef struct {bit ready; bit send; int credits; int wptr; bit drained; bit ov;} exp_t;
  exp_t q[$];
  int sq[$];
  int total = 0, bad = 0;
  int m_cred, m_sends, m_st;
  bit m_ov;
  exp_t mr;
  task automatic chk(string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask
  task automatic model_reset();
    m_cred = 4; m_sends = 0; m_st = 0; m_ov = 0;
  endtask
  // one cycle: drive inputs, push what the remote-FIFO bookkeeping says must be seen, advance the model
  task automatic step(bit v, int ret, bit d);
    exp_t r;
    int n;
    @(posedge clk); #1;
    v_i = v; ret_i = 2'(ret); drain_i = d;
    r.ready = (m_st == 0) && !d && (m_cred != 0);
    r.send = v && r.ready;
    r.credits = m_cred;
    r.wptr = m_sends % 4;
    r.drained = (m_st == 2);
    r.ov = m_ov;
    q.push_back(r);
    if (r.send) sq.push_back(r.wptr);
    n = m_cred - int'(r.send) + ret;
    if (n > 4) begin n = 4; m_ov = 1; end
    if (!d) m_st = 0;
    else if (m_st == 0) m_st = 1;
    else if (m_st == 1 && m_cred == 4) m_st = 2;
    m_cred = n;
    m_sends += int'(r.send);
  endtask
  task automatic async_reset();
    @(posedge clk); #7;
    rst = 1; drain_i = 0; v_i = 0; ret_i = 0;
    #1;
    chk("rst_credits", 32'(credits_o), 4);
    chk("rst_wptr", 32'(wptr_o), 0);
    chk("rst_drained", 32'(drained_o), 0);
    chk("rst_overflow", 32'(overflow_o), 0);
    chk("rst_ready", 32'(ready_o), 1);
    #1 rst = 0;
    model_reset();
  endtask
  always @(negedge clk) if (!rst) begin
    if (q.size() != 0) begin
      mr = q.pop_front();
      chk("ready", 32'(ready_o), 32'(mr.ready));
      chk("send", 32'(send_o), 32'(mr.send));
      chk("credits", 32'(credits_o), 32'(mr.credits));
      chk("wptr", 32'(wptr_o), 32'(mr.wptr));
      chk("drained", 32'(drained_o), 32'(mr.drained));
      chk("overflow", 32'(overflow_o), 32'(mr.ov));
    end
    if (send_o) begin
      if (sq.size() == 0) begin
        total++; bad++;
        $display("FAIL send_unexpected got=1 want=0 wptr=%0d", wptr_o);
      end else chk("send_wptr", 32'(wptr_o), 32'(sq.pop_front()));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end
  initial begin
    int cnt, x, ret;
    bit d;
    model_reset();
    #12 rst = 0;
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(0, 2, 0);
    step(1, 2, 0);
    step(0, 2, 0);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(1, 0, 1);
    step(1, 2, 1);
    step(1, 1, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 1);
    async_reset();
    step(1, 0, 0);
    d = 0;
    for (int i = 0; i < 3000; i++) begin
      x = int'($urandom % 16);
      ret = x < 8 ? 0 : x < 12 ? 1 : x < 15 ? 2 : 3;
      if ($urandom % 40 == 0) d = ~d;
      step(($urandom % 4) != 0, ret, d);
    end
    step(0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    chk("queue_left", 32'(q.size()), 0);
    chk("send_queue_left", 32'(sq.size()), 0);
    async_reset();
    @(posedge clk); #1;
    v1 = 1;
    cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (send1) cnt++;
      if (i == 1023) chk("big_wptr_last", 32'(wptr1), 1023);
    end
    @(negedge clk);
    chk("big_wptr_wrap", 32'(wptr1), 0);
    chk("big_credits", 32'(cred1), 0);
    chk("big_ready", 32'(ready1), 0);
    chk("big_send", 32'(send1), 0);
    chk("big_count", 32'(cnt), 1024);
    chk("big_overflow", 32'(ov1), 0);
    v1 = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bsg_fifo_credit_sender.md
Name: bsg_fifo_credit_sender

Overview:
- Sender-side counterpart to a remote FIFO's occupancy tracker.
- Holds a credit count equal to the free slots in the remote FIFO (depth els_p), plus a write-pointer mirror matching the remote write pointer.
- Gates client sends on credit availability; the remote side returns credits as it dequeues.
- A drain FSM lets software quiesce the link: stop sending and wait until every credit has returned.

Parameters:
- els_p, 1024: remote FIFO depth = initial credit count; any value >= 2.
- max_return_p, 4: maximum credits returned in one cycle.
- Derived ptr_width_lp = $clog2(els_p) (10 at default).
- Derived cnt_width_lp = $clog2(els_p+1) (11 at default).
- Derived ret_width_lp = $clog2(max_return_p+1) (3 at default).

Ports:
- clk_i  input  1  the single clock.
- reset_i  input  1  asynchronous, active-high reset.
- v_i  input  1  client has an element to send.
- ready_o  output  1  send permitted this cycle; a send happens when v_i & ready_o.
- send_o  output  1  combinational v_i & ready_o; launches the element to the link.
- wptr_r_o  output  ptr_width_lp  remote slot address for the current send (registered).
- credit_return_i  input  ret_width_lp  credits returned this cycle, 0..max_return_p.
- credits_r_o  output  cnt_width_lp  registered credit count.
- drain_i  input  1  level request to quiesce.
- drained_o  output  1  registered; high while drained.
- overflow_o  output  1  sticky error flag.

Behaviour:
- Reset (async assert, sampled deassert) sets: credits_r_o = els_p, wptr_r_o = 0, state = eRun, drained_o = 0, overflow_o = 0.
- Send rule:
  - ready_o = (state == eRun) & ~drain_i & (credits_r_o != 0).
  - ready_o depends on registered state only, plus drain_i; there is no path from credit_return_i to ready_o, so there is no same-cycle bypass.
- Credit arithmetic each cycle: credits_n = credits_r_o - send_o + credit_return_i, computed at cnt_width_lp+1 bits.
  - Simultaneous send and return of 1 leaves the count unchanged.
- Overflow: if credits_n > els_p, credits_r_o saturates at els_p and overflow_o sets. overflow_o clears only on reset.
- Out-of-range return: credit_return_i > max_return_p is illegal; the design must still apply the saturation rule.
- Underflow cannot occur, because ready_o requires credits != 0.
- Pointer: on send_o, wptr_r_o <= (wptr_r_o == els_p-1) ? 0 : wptr_r_o + 1. The explicit wrap also covers non-power-of-two els_p.
- Latency: send_o is visible in credits_r_o and wptr_r_o one cycle later. A return is likewise visible one cycle later.
- FSM states: eRun, eDrain, eDone.
  - eRun -> eDrain when drain_i = 1.
  - eDrain -> eDone when credits_r_o == els_p.
  - eDrain -> eRun if drain_i drops first (abort).
  - eDone -> eRun when drain_i = 0.
  - drained_o = (state == eDone).
- In eDrain and eDone: ready_o = 0 and no sends occur; credit returns are still accepted. A return in eDone can only overflow, which is flagged and saturated.
- drain_i asserted while credits == els_p: eRun -> eDrain, then eDone the next cycle, so drained_o rises 2 cycles after drain_i.
- Reset mid-drain returns to eRun with full credits. Any in-flight remote returns must be discarded by the system; this block does not handle them.

Test Plan (els_p = 4, max_return_p = 2 unless noted):
- Reset -> credits_r_o = 4, wptr_r_o = 0, ready_o = 0 until v_i is irrelevant; ready_o = 1 with drain_i = 0, drained_o = 0, overflow_o = 0.
- v_i = 1 for 6 cycles, no returns -> exactly 4 send_o pulses, wptr_r_o 0->1->2->3->0, credits reach 0, ready_o = 0 on cycles 5-6.
- At credits = 0, credit_return_i = 1 with v_i = 1 -> no send that cycle; next cycle ready_o = 1, send occurs, credits return to 0.
- At credits = 2, send plus credit_return_i = 2 in the same cycle -> credits = 3; then credit_return_i = 2 at credits = 3 -> credits = 4, overflow_o = 1 and stays 1.
- At credits = 1, drain_i = 1 with v_i = 1 -> no send; return 3 credits over 2 cycles -> drained_o rises 1 cycle after credits = 4; drop drain_i -> eRun, ready_o = 1 next cycle.
- In eDrain, pulse reset_i asynchronously mid-cycle -> outputs reach reset values immediately; with drain_i = 0 after reset, state = eRun.
- els_p = 1024 default: 1024 back-to-back sends -> wptr_r_o wraps 1023->0, credits_r_o = 0.
